// File: rtl/dcache_2way_top.sv
// rtl/dcache_2way_top.sv - 2-way set-associative write-back write-allocate L1 data cache
// Register-array storage, 1-bit LRU per set, invalid-way-first victim selection.
module dcache_2way_top #(
    parameter int LINE_W = 256,
    parameter int SETS   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [31:0]       mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;
    localparam int LINE_A = TAG_W + IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILLED} state_t;

    state_t              state_q, state_d;
    logic                mem_enable_q, mem_enable_d;
    logic                mem_write_q, mem_write_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0]   mem_data_q, mem_data_d;
    logic                victim_q, victim_d;
    logic [LINE_A-1:0]   req_line_q, req_line_d;

    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     valid_d [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     dirty_d [2];
    logic [SETS-1:0]     lru_q, lru_d;
    logic [TAG_W-1:0]    tag_q  [2][SETS];
    logic [LINE_W-1:0]   data_q [2][SETS];

    logic                data_we, tag_we, wr_way;
    logic [IDX_W-1:0]    wr_idx;
    logic [LINE_W-1:0]   wr_line;

    logic                req, hit0, hit1, hit, victim;
    logic [TAG_W-1:0]    req_tag, line_tag;
    logic [IDX_W-1:0]    req_idx, line_idx;
    logic [WSEL_W-1:0]   req_word;
    logic [LINE_W-1:0]   hit_line, merged_line;
    logic                unused_addr;

    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign req_tag     = p1_addr_i[31 -: TAG_W];
    assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign req_word    = p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^p1_addr_i[1:0];
    assign line_tag    = req_line_q[LINE_A-1 -: TAG_W];
    assign line_idx    = req_line_q[IDX_W-1:0];

    assign hit0     = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit1     = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit      = hit0 | hit1;
    assign hit_line = data_q[hit1][req_idx];

    assign p1_data_o = hit ? hit_line[{req_word, 5'd0} +: 32] : 32'd0;
    // Stall holds through FILLED so the completing access is always taken in IDLE,
    // which is where stores are merged into the line.
    assign p1_stall_o = req && (!hit || state_q != IDLE);

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

    always_comb begin
        merged_line = hit_line;
        merged_line[{req_word, 5'd0} +: 32] = p1_data_i;
    end

    always_comb begin
        if (!valid_q[0][req_idx]) begin
            victim = 1'b0;
        end else if (!valid_q[1][req_idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[req_idx];
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        victim_d     = victim_q;
        req_line_d   = req_line_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        lru_d        = lru_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        wr_way       = hit1;
        wr_idx       = req_idx;
        wr_line      = merged_line;
        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    lru_d[req_idx] = hit0;
                    if (p1_MemWrite_i) begin
                        data_we                 = 1'b1;
                        dirty_d[hit1][req_idx]  = 1'b1;
                    end
                end else if (req) begin
                    victim_d     = victim;
                    req_line_d   = {req_tag, req_idx};
                    mem_enable_d = 1'b1;
                    if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[victim][req_idx], req_idx, {OFF_W{1'b0}}};
                        mem_data_d  = data_q[victim][req_idx];
                    end else begin
                        state_d     = REFILL;
                        mem_write_d = 1'b0;
                        mem_addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d                     = REFILL;
                    mem_write_d                 = 1'b0;
                    mem_addr_d                  = {req_line_q, {OFF_W{1'b0}}};
                    dirty_d[victim_q][line_idx] = 1'b0;
                end
            end
            REFILL: begin
                if (mem_ack_i) begin
                    state_d                     = FILLED;
                    mem_enable_d                = 1'b0;
                    data_we                     = 1'b1;
                    tag_we                      = 1'b1;
                    wr_way                      = victim_q;
                    wr_idx                      = line_idx;
                    wr_line                     = mem_data_i;
                    valid_d[victim_q][line_idx] = 1'b1;
                    dirty_d[victim_q][line_idx] = 1'b0;
                    lru_d[line_idx]             = ~victim_q;
                end
            end
            FILLED: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_data_q   <= '0;
            victim_q     <= 1'b0;
            req_line_q   <= '0;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            victim_q     <= victim_d;
            req_line_q   <= req_line_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            lru_q        <= lru_d;
        end
    end

    // Contents are qualified by valid, so the storage arrays need no reset.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_q[wr_way][wr_idx] <= wr_line;
        end
        if (tag_we) begin
            tag_q[wr_way][wr_idx] <= line_tag;
        end
    end
endmodule
